hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core.
- Detects load-use hazards and inserts one bubble by driving the control decoder's Re input.
- Freezes the whole pipeline while the multi-cycle data memory has not acknowledged an access, and flushes IF/ID on a taken branch.
- Detects a memory timeout, locks the pipeline, and keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- MAX_WAIT, 15: maximum consecutive memory-busy cycles tolerated before timeout (1..255).
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rt  in  5  destination register of the instruction in EX.
- if_id_opcode  in  6  opcode of the instruction in ID.
- if_id_rs  in  5  rs field of the instruction in ID.
- if_id_rt  in  5  rt field of the instruction in ID.
- ex_mem_memread  in  1  MEM-stage load.
- ex_mem_memwrite  in  1  MEM-stage store.
- mem_ready  in  1  data memory completes the MEM-stage access this cycle.
- branch_taken  in  1  branch resolved taken in ID.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID register load enable.
- ctrl_re  out  1  forces the control decoder outputs to zero (bubble).
- pipe_hold  out  1  holds the ID/EX, EX/MEM and MEM/WB registers.
- if_id_flush  out  1  clears IF/ID to a nop.
- mem_timeout  out  1  sticky timeout flag.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- Internal states: RUN, WAIT, ERR. There is also a wait_cnt of 8 bits.
- Source-use decode:
  - uses_rs=1 for opcodes 000000, 100011 and 101011.
  - uses_rt=1 for opcodes 000000 and 101011.
  - All other opcodes use neither.
- Load-use hazard: lu_hz = id_ex_memread & (id_ex_rt!=0) & ((uses_rs & id_ex_rt==if_id_rs) | (uses_rt & id_ex_rt==if_id_rt)).
- Memory busy: mem_busy = (ex_mem_memread | ex_mem_memwrite) & !mem_ready.
- Outputs are combinational from state and inputs, evaluated in strict priority order:
  1. rst=1: pc_write=0, if_id_write=0, ctrl_re=1, pipe_hold=0, if_id_flush=1.
  2. state==ERR or mem_busy (freeze): pc_write=0, if_id_write=0, pipe_hold=1, ctrl_re=0, if_id_flush=0. A branch or hazard presented during a freeze is ignored this cycle; it is re-evaluated once the freeze ends.
  3. lu_hz (bubble): pc_write=0, if_id_write=0, ctrl_re=1, pipe_hold=0, if_id_flush=0. branch_taken is ignored, because the branch's operands are not yet valid and it re-resolves next cycle.
  4. branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, ctrl_re=0, pipe_hold=0.
  5. Otherwise: pc_write=1, if_id_write=1, ctrl_re=0, pipe_hold=0, if_id_flush=0.
- Zero latency: the hazard response appears in the same cycle as the inputs.
- Load-use costs exactly one bubble. After the bubble the load has moved to MEM, so lu_hz falls naturally without extra state.
- State transitions, all at the clock edge:
  - RUN -> WAIT when mem_busy; wait_cnt <= 1.
  - WAIT, mem_busy and wait_cnt < MAX_WAIT: stay in WAIT; wait_cnt++.
  - WAIT, mem_busy and wait_cnt == MAX_WAIT: go to ERR; mem_timeout <= 1.
  - WAIT, !mem_busy: go to RUN; wait_cnt <= 0. In that cycle the outputs follow priority 3..5 normally.
  - ERR: terminal until rst.
- Memory handshake:
  - A single-cycle access (mem_ready=1 in the first MEM cycle) causes no stall.
  - An access that completes after N busy cycles stalls for exactly N cycles.
  - Timeout: with MAX_WAIT=15, 15 busy cycles are tolerated. On the 16th consecutive busy cycle the block enters ERR, and mem_timeout rises at the edge ending that cycle.
- stall_cnt:
  - At each edge with rst=0 and pc_write=0, stall_cnt++.
  - It saturates at all-ones and holds, with no wrap.
  - It also counts cycles spent in ERR.
- Reset:
  - At a rising edge with rst=1: state <= RUN, wait_cnt <= 0, stall_cnt <= 0, mem_timeout <= 0.
  - Reset asserted mid-WAIT or in ERR has the same effect and overrides everything.
  - The cycle after rst falls evaluates normally.
- Simultaneous lu_hz and mem_busy: freeze wins, and no bubble is inserted this cycle. The hazard is re-detected after the freeze.

Test Plan:
- Load-use: lw $8 in EX (id_ex_memread=1, id_ex_rt=8), add with rs=8 in ID -> one cycle of ctrl_re=1, pc_write=0, if_id_write=0; next cycle all normal; stall_cnt=1.
- No false hazard:
  - id_ex_rt=0 with if_id_rs=0 -> no stall.
  - lw in ID with rt matching id_ex_rt -> no stall, because uses_rt=0 for a load.
- Memory wait: sw in MEM with mem_ready low for 3 cycles -> pipe_hold=1 and pc_write=0 for exactly 3 cycles; RUN in the 4th; stall_cnt=3.
- Timeout: MAX_WAIT=15, mem_ready held low for 16 cycles -> mem_timeout=1 after the 16th, freeze persists with mem_ready=1; rst for one cycle -> mem_timeout=0, normal flow.
- Priority: lu_hz together with branch_taken -> bubble with no flush; next cycle branch_taken -> if_id_flush=1, pc_write=1.
- Saturation: STALL_CNT_W=4 with 20 stall cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use bubbles, memory-wait
// freezes with timeout lock-out, branch flush and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned MAX_WAIT    = 15,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_ex_memread,
    input  logic [4:0]             id_ex_rt,
    input  logic [5:0]             if_id_opcode,
    input  logic [4:0]             if_id_rs,
    input  logic [4:0]             if_id_rt,
    input  logic                   ex_mem_memread,
    input  logic                   ex_mem_memwrite,
    input  logic                   mem_ready,
    input  logic                   branch_taken,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   ctrl_re,
    output logic                   pipe_hold,
    output logic                   if_id_flush,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [1:0]             state_q, state_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic                   mem_timeout_q, mem_timeout_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic uses_rs, uses_rt, lu_hz, mem_busy;

    assign uses_rs = (if_id_opcode == OP_RTYPE) || (if_id_opcode == OP_LW) ||
                     (if_id_opcode == OP_SW);
    assign uses_rt = (if_id_opcode == OP_RTYPE) || (if_id_opcode == OP_SW);

    assign lu_hz = id_ex_memread && (id_ex_rt != 5'd0) &&
                   ((uses_rs && (id_ex_rt == if_id_rs)) ||
                    (uses_rt && (id_ex_rt == if_id_rt)));

    assign mem_busy = (ex_mem_memread || ex_mem_memwrite) && !mem_ready;

    // Zero-latency hazard response; earlier branches take priority.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        ctrl_re     = 1'b0;
        pipe_hold   = 1'b0;
        if_id_flush = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ctrl_re     = 1'b1;
            if_id_flush = 1'b1;
        end else if (state_q == ERR || mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (lu_hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ctrl_re     = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            WAIT: begin
                if (!mem_busy) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q >= 8'(MAX_WAIT)) begin
                    state_d       = ERR;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    // Saturating: pins at all-ones instead of wrapping.
    assign stall_cnt_d = (!pc_write && stall_cnt_q != '1) ? stall_cnt_q + 1'b1
                                                          : stall_cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with an expected-result queue; a second
// instance with a 4-bit counter exercises stall_cnt saturation.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_ex_memread;
    logic [4:0] id_ex_rt;
    logic [5:0] if_id_opcode;
    logic [4:0] if_id_rs, if_id_rt;
    logic       ex_mem_memread, ex_mem_memwrite, mem_ready, branch_taken;

    logic        pc_write, if_id_write, ctrl_re, pipe_hold, if_id_flush, mem_timeout;
    logic [15:0] stall_cnt;
    logic        s_pc_write, s_if_id_write, s_ctrl_re, s_pipe_hold, s_if_id_flush, s_mem_timeout;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .rst(rst),
        .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .ctrl_re(ctrl_re),
        .pipe_hold(pipe_hold), .if_id_flush(if_id_flush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    hazard_stall_ctrl #(.MAX_WAIT(15), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .if_id_opcode(if_id_opcode), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .ctrl_re(s_ctrl_re),
        .pipe_hold(s_pipe_hold), .if_id_flush(s_if_id_flush),
        .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt)
    );

    // {pc_write, if_id_write, ctrl_re, pipe_hold, if_id_flush}
    localparam logic [4:0] O_NORM = 5'b11000;
    localparam logic [4:0] O_BUB  = 5'b00100;
    localparam logic [4:0] O_FRZ  = 5'b00010;
    localparam logic [4:0] O_BR   = 5'b11001;
    localparam logic [4:0] O_RST  = 5'b00101;

    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_J  = 6'b000010;

    typedef struct {
        logic [4:0]  outs;
        logic        to;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;
    logic        exp_to = 1'b0;
    logic [15:0] exp_cnt = '0;
    logic [3:0]  exp_cnt4 = '0;

    task automatic step(input logic r, input logic mr, input logic [4:0] ex_rt,
                        input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic emr, input logic emw, input logic rdy,
                        input logic br, input logic [4:0] exp_outs);
        exp_t e, got;
        logic [4:0] obs;
        @(negedge clk);
        rst = r; id_ex_memread = mr; id_ex_rt = ex_rt; if_id_opcode = op;
        if_id_rs = rs; if_id_rt = rt; ex_mem_memread = emr;
        ex_mem_memwrite = emw; mem_ready = rdy; branch_taken = br;
        e.outs = exp_outs; e.to = exp_to; e.cnt = exp_cnt; e.cnt4 = exp_cnt4;
        sb.push_back(e);
        #2;
        step_no++;
        got = sb.pop_front();
        obs = {pc_write, if_id_write, ctrl_re, pipe_hold, if_id_flush};
        checks++;
        assert (obs === got.outs) else begin
            errors++;
            $error("FAIL outs step=%0d got=%b exp=%b", step_no, obs, got.outs);
        end
        checks++;
        assert (mem_timeout === got.to) else begin
            errors++;
            $error("FAIL mem_timeout step=%0d got=%b exp=%b", step_no, mem_timeout, got.to);
        end
        checks++;
        assert (stall_cnt === got.cnt) else begin
            errors++;
            $error("FAIL stall_cnt step=%0d got=%0d exp=%0d", step_no, stall_cnt, got.cnt);
        end
        checks++;
        assert (s_stall_cnt === got.cnt4) else begin
            errors++;
            $error("FAIL stall_cnt_sat step=%0d got=%0d exp=%0d", step_no, s_stall_cnt, got.cnt4);
        end
        // Reference counter update for the coming edge.
        if (r) begin
            exp_cnt  = '0;
            exp_cnt4 = '0;
        end else if (!exp_outs[4]) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 4'd1;
        end
    endtask

    initial begin
        rst = 1'b1; id_ex_memread = 1'b0; id_ex_rt = '0; if_id_opcode = '0;
        if_id_rs = '0; if_id_rt = '0; ex_mem_memread = 1'b0;
        ex_mem_memwrite = 1'b0; mem_ready = 1'b1; branch_taken = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        step(1, 0, 5'd0, OP_R, 5'd0, 5'd0, 0, 0, 1, 0, O_RST);
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 0, 1, 0, O_NORM);

        // Load-use on rs: one bubble, then normal flow
        step(0, 1, 5'd8, OP_R, 5'd8, 5'd3, 0, 0, 1, 0, O_BUB);
        step(0, 0, 5'd8, OP_R, 5'd8, 5'd3, 0, 0, 1, 0, O_NORM);

        // No false hazards: $zero, lw rt, jump, non-matching
        step(0, 1, 5'd0, OP_R, 5'd0, 5'd0, 0, 0, 1, 0, O_NORM);
        step(0, 1, 5'd8, OP_LW, 5'd3, 5'd8, 0, 0, 1, 0, O_NORM);
        step(0, 1, 5'd8, OP_J, 5'd8, 5'd8, 0, 0, 1, 0, O_NORM);
        step(0, 1, 5'd8, OP_R, 5'd7, 5'd9, 0, 0, 1, 0, O_NORM);

        // Hazards via rt for sw and R-type, and via rs for lw
        step(0, 1, 5'd8, OP_SW, 5'd3, 5'd8, 0, 0, 1, 0, O_BUB);
        step(0, 1, 5'd9, OP_R, 5'd3, 5'd9, 0, 0, 1, 0, O_BUB);
        step(0, 1, 5'd4, OP_LW, 5'd4, 5'd1, 0, 0, 1, 0, O_BUB);

        // sw in MEM waits 3 cycles; hazard and branch ignored during freeze
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 1, 0, 0, O_FRZ);
        step(0, 1, 5'd8, OP_R, 5'd8, 5'd2, 0, 1, 0, 1, O_FRZ);
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 1, 0, 1, O_FRZ);
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 1, 1, 0, O_NORM);

        // Single-cycle access never stalls
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 1, 0, 1, 0, O_NORM);

        // Bubble beats branch; branch re-resolves and flushes next cycle
        step(0, 1, 5'd5, OP_R, 5'd5, 5'd2, 0, 0, 1, 1, O_BUB);
        step(0, 0, 5'd5, OP_R, 5'd5, 5'd2, 0, 0, 1, 1, O_BR);

        // Exactly MAX_WAIT busy cycles is tolerated; hazard re-detected on exit
        for (int i = 0; i < 15; i++)
            step(0, 1, 5'd6, OP_R, 5'd6, 5'd2, 1, 0, 0, 0, O_FRZ);
        step(0, 1, 5'd6, OP_R, 5'd6, 5'd2, 1, 0, 1, 0, O_BUB);
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 0, 1, 0, O_NORM);

        // 16 busy cycles times out; ERR freezes regardless of mem_ready
        for (int i = 0; i < 16; i++)
            step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 1, 0, 0, 0, O_FRZ);
        exp_to = 1'b1;
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 1, 0, 1, 0, O_FRZ);
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 0, 1, 1, O_FRZ);
        step(0, 1, 5'd3, OP_R, 5'd3, 5'd2, 0, 0, 1, 0, O_FRZ);

        // One-cycle reset clears the lock-out
        step(1, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 0, 1, 0, O_RST);
        exp_to = 1'b0;
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 0, 1, 0, O_NORM);
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 0, 1, 1, O_BR);

        // Reset mid-WAIT, then a fresh wait must count from scratch
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 1, 0, 0, 0, O_FRZ);
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 1, 0, 0, 0, O_FRZ);
        step(1, 0, 5'd0, OP_R, 5'd1, 5'd2, 1, 0, 0, 0, O_RST);
        for (int i = 0; i < 15; i++)
            step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 1, 0, 0, 0, O_FRZ);
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 1, 0, 1, 0, O_NORM);
        step(0, 0, 5'd0, OP_R, 5'd1, 5'd2, 0, 0, 1, 0, O_NORM);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
